bram_stream_reader: RTL and testbench



---
 rtl/bram_rd_pkg.sv | 13 +
 rtl/stream_fifo2.sv | 73 +++++++
 rtl/bram_stream_reader.sv | 132 +++++++++++++
 tb/tb_bram_stream_reader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_pkg.sv
// Shared definitions for the BRAM read sequencer and its stream FIFO.
package bram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO carrying a data word plus a last flag.
// The head entry is always slot 0, so head outputs come straight from flops.
// Pops on an empty FIFO and pushes into a full FIFO without a pop are ignored.
module stream_fifo2
  import bram_rd_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_push_data,
  input  logic             i_push_last,
  input  logic             i_pop,
  output logic [OCC_W-1:0] o_occ,
  output logic [W-1:0]     o_head_data,
  output logic             o_head_last
);

  logic [W-1:0]     r_d0, r_d1;
  logic             r_l0, r_l1;
  logic [OCC_W-1:0] r_occ;
  logic             w_pop, w_push;

  assign w_pop  = i_pop && (r_occ != '0);
  assign w_push = i_push && ((r_occ != OCC_W'(FIFO_DEPTH)) || w_pop);

  // Slot 0 is the head; slot 1 shifts forward on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_l0  <= 1'b0;
      r_l1  <= 1'b0;
      r_occ <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == '0) begin
            r_d0 <= i_push_data;
            r_l0 <= i_push_last;
          end else begin
            r_d1 <= i_push_data;
            r_l1 <= i_push_last;
          end
          r_occ <= r_occ + 1'b1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_l0  <= r_l1;
          r_occ <= r_occ - 1'b1;
        end
        2'b11: begin
          if (r_occ == OCC_W'(1)) begin
            r_d0 <= i_push_data;
            r_l0 <= i_push_last;
          end else begin
            r_d0 <= r_d1;
            r_l0 <= r_l1;
            r_d1 <= i_push_data;
            r_l1 <= i_push_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_occ       = r_occ;
  assign o_head_data = r_d0;
  assign o_head_last = r_l0;

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side sequencer: issues a run of BRAM reads, absorbs the one-cycle
// read latency and streams words out with valid/ready backpressure.
// Optional feature macro: BRAM_READER_STRIDE_EN adds the stride port;
// otherwise the address step is fixed at 1.
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   count,
`ifdef BRAM_READER_STRIDE_EN
  input  logic [AWIDTH-1:0] stride,
`endif
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] rd_addr,
  output logic              rd_ce,
  input  logic [DWIDTH-1:0] rd_data,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  state_t            r_state;
  logic [AWIDTH-1:0] r_addr;
  logic [AWIDTH-1:0] r_step;
  logic [AWIDTH:0]   r_count;
  logic [AWIDTH:0]   r_issued;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_busy;
  logic              r_done;

  logic [OCC_W-1:0]  w_occ;
  logic [DWIDTH-1:0] w_head_data;
  logic              w_head_last;
  logic              w_valid;
  logic              w_pop;
  logic [OCC_W:0]    w_pend;
  logic              w_issue_last;
  logic              w_rd_ce;

  assign w_valid      = (w_occ != '0);
  assign w_pop        = w_valid && m_ready;
  assign w_issue_last = (r_issued == r_count - 1'b1);
  // Words already owned (queued or in flight) after this cycle's pop; issuing
  // only while this is below the FIFO depth keeps the FIFO from overflowing.
  assign w_pend  = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight} - {{OCC_W{1'b0}}, w_pop};
  assign w_rd_ce = (r_state == ST_READ) && (r_issued < r_count) &&
                   (w_pend < (OCC_W+1)'(FIFO_DEPTH));

  // Sequencer FSM: latches the command, walks addresses, waits for last pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_step          <= '0;
      r_count         <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_rd_ce;
      r_inflight_last <= w_rd_ce && w_issue_last;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr   <= base_addr;
            r_count  <= count;
            r_issued <= '0;
`ifdef BRAM_READER_STRIDE_EN
            r_step   <= stride;
`else
            r_step   <= AWIDTH'(1);
`endif
            if (count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (w_rd_ce) begin
            r_addr   <= r_addr + r_step;
            r_issued <= r_issued + 1'b1;
            if (w_issue_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_head_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  stream_fifo2 #(.W(DWIDTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (rd_data),
    .i_push_last (r_inflight_last),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head_data (w_head_data),
    .o_head_last (w_head_last)
  );

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_addr = r_addr;
  assign rd_ce   = w_rd_ce;
  assign m_data  = w_head_data;
  assign m_valid = w_valid;
  assign m_last  = w_head_last && w_valid;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a registered-read RAM model and
// a scoreboard of expected addresses and stream words.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  base_addr = '0;
  logic [9:0]  count = '0;
  logic [8:0]  stride = 9'd1;
  logic        busy, done, rd_ce, m_valid, m_last;
  logic        m_ready = 1'b1;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic [31:0] m_data;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;
  exp_t       exp_q[$];
  logic [8:0] addr_q[$];

  always #5 clk = ~clk;

  bram_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
`ifdef BRAM_READER_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_ce     (rd_ce),
    .rd_data   (rd_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  // RAM model: RAM[i] = i, one-cycle registered read.
  always @(posedge clk) if (rd_ce) rd_data <= {23'd0, rd_addr};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_ce) begin
        if (addr_q.size() == 0) check("rd_ce_extra", rd_ce, 0);
        else check("rd_addr", rd_addr, addr_q.pop_front());
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("m_valid_extra", m_valid, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("m_data", m_data, e.data);
          check("m_last", m_last, e.last);
        end
      end
      check("fifo_occ_le2", dut.w_occ <= 2, 1);
    end
  end

  function automatic logic ready_at(input int mode, input int p);
    if (mode == 0) return 1'b1;
    if (p >= 5 && p <= 9) return 1'b0;
    return p[0];
  endfunction

  // Issue one run; exp_k is the expected cycle (after start edge) of done, or -1.
  task automatic do_run(input logic [8:0] base, input logic [9:0] cnt,
                        input logic [8:0] stp, input int mode, input int exp_k);
    int k;
    logic [8:0] a;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; count = cnt; stride = stp;
    m_ready = ready_at(mode, 1);
    a = base;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_t e;
      addr_q.push_back(a);
      e.data = {23'd0, a};
      e.last = (i == int'(cnt) - 1);
      exp_q.push_back(e);
`ifdef BRAM_READER_STRIDE_EN
      a = a + stp;
`else
      a = a + 9'd1;
`endif
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (cnt == 0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      @(posedge clk); #1;
      check("zero_done_pulse", done, 0);
      check("zero_m_valid", m_valid, 0);
      return;
    end
    check("busy_t1", busy, 1);
    check("rd_ce_t1", rd_ce, 1);
    check("rd_addr_t1", rd_addr, base);
    k = 1;
    while (k <= 300) begin
      @(negedge clk);
      if (done) break;
      if (mode == 1 && k >= 7 && k <= 9) check("stall_rd_ce", rd_ce, 0);
      @(posedge clk); #1;
      k++;
      m_ready = ready_at(mode, k);
    end
    if (k > 300) check("done_timeout", 0, 1);
    else if (exp_k >= 0) check("done_latency", k, exp_k);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("exp_q_empty", exp_q.size(), 0);
    check("addr_q_empty", addr_q.size(), 0);
    m_ready = 1'b1;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_ce", rd_ce, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    rst = 1'b0;

    do_run(9'h010, 10'd4, 9'd1, 0, 7);
    do_run(9'h020, 10'd0, 9'd1, 0, -1);
    repeat (3) @(negedge clk) check("zero_no_valid", m_valid, 0);
    do_run(9'h1FE, 10'd4, 9'd1, 0, 7);
    do_run(9'h100, 10'd8, 9'd1, 1, -1);

    // Reset in the middle of a run.
    hs_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 9'h080; count = 10'd8; stride = 9'd1;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      addr_q.push_back(9'h080 + 9'(i));
      e.data = 32'h80 + 32'(i);
      e.last = (i == 7);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (hs_cnt < 3 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= 50) check("hs_timeout", 0, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst_rd_ce", rd_ce, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_last", m_last, 0);
    check("mid_rst_m_data", m_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_done", done, 0);
      check("post_rst_no_valid", m_valid, 0);
    end
    do_run(9'h040, 10'd2, 9'd1, 0, 5);

`ifdef BRAM_READER_STRIDE_EN
    do_run(9'h000, 10'd4, 9'd3, 0, 7);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
